// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: two-flop synchroniser, stability-count
// debounce FSM, registered level plus one-cycle rise/fall pulses.
//
// state       | meaning
// ------------+----------------------------------------------------------
// LOW_STABLE  | level 0, synchronised input agrees with level
// LOW_CHECK   | level 0, counting consecutive high samples toward a flip
// HIGH_STABLE | level 1, synchronised input agrees with level
// HIGH_CHECK  | level 1, counting consecutive low samples toward a flip
module btn_debounce #(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall,
  output logic             any_change
);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_CHECK   = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_CHECK  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // A single required sample means the first mismatch flips straight from STABLE.
  localparam bit BYPASS = (STABLE_CYCLES == 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      rise_d[i]  = 1'b0;
      fall_d[i]  = 1'b0;
      case (state_q[i])
        LOW_STABLE: begin
          if (sync2_q[i]) begin
            if (BYPASS) begin
              state_d[i] = HIGH_STABLE;
              level_d[i] = 1'b1;
              rise_d[i]  = 1'b1;
            end else begin
              state_d[i] = LOW_CHECK;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        LOW_CHECK: begin
          if (!sync2_q[i]) begin
            state_d[i] = LOW_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + CNT_ONE == CNT_TARGET) begin
            state_d[i] = HIGH_STABLE;
            level_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HIGH_STABLE: begin
          if (!sync2_q[i]) begin
            if (BYPASS) begin
              state_d[i] = LOW_STABLE;
              level_d[i] = 1'b0;
              fall_d[i]  = 1'b1;
            end else begin
              state_d[i] = HIGH_CHECK;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        HIGH_CHECK: begin
          if (sync2_q[i]) begin
            state_d[i] = HIGH_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + CNT_ONE == CNT_TARGET) begin
            state_d[i] = LOW_STABLE;
            level_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = LOW_STABLE;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= LOW_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random raw
// activity, compared against a run-length debounce model.
module tb_btn_debounce;
  localparam int W  = 2;
  localparam int SC = 4;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] btn_raw = '0;
  logic [W-1:0] btn_level, btn_rise, btn_fall;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  // Model: pin delay line, debounced level, and length of the current run of
  // samples disagreeing with that level.
  logic [W-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  logic         m_any;
  int           run [W];

  btn_debounce #(.WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  function automatic logic [3*W:0] expv();
    return {m_lvl, m_rise, m_fall, m_any};
  endfunction

  function automatic logic [3*W:0] actv();
    return {btn_level, btn_rise, btn_fall, any_change};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
    for (int c = 0; c < W; c++) run[c] = 0;
  endtask

  task automatic tick(input logic [W-1:0] raw);
    btn_raw = raw;
    @(posedge clk);
    if (!rst) begin
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < W; c++) begin
        if (m_s2[c] != m_lvl[c]) begin
          run[c]++;
          if (run[c] == SC) begin
            m_lvl[c] = m_s2[c];
            if (m_s2[c]) m_rise[c] = 1'b1;
            else         m_fall[c] = 1'b1;
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
      m_any = |(m_rise | m_fall);
      m_s2  = m_s1;
      m_s1  = raw;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick('0);
    tick('0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick(2'b11);
      checks++;
      if (actv() !== '0) begin
        errors++;
        $display("FAIL reset_hold got=%b want=0", actv());
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick(2'b11);
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL reset_release_e%0d got=%b want=%b", e, actv(), expv());
      end
      if (e == 6) begin
        checks++;
        if (btn_level !== 2'b11 || btn_rise !== 2'b11 || any_change !== 1'b1) begin
          errors++;
          $display("FAIL reset_rise_edge6 got lvl=%b rise=%b any=%b want 11 11 1",
                   btn_level, btn_rise, any_change);
        end
      end
      if (e == 7) begin
        checks++;
        if (btn_rise !== 2'b00 || any_change !== 1'b0) begin
          errors++;
          $display("FAIL reset_pulse_end got rise=%b any=%b want 00 0", btn_rise, any_change);
        end
      end
    end
  endtask

  task automatic test_press();
    int rises = 0, falls = 0;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      tick(2'b01);
      rises += int'(btn_rise[0]);
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL press_e%0d got=%b want=%b", e, actv(), expv());
      end
      if (e == 5 || e == 6) begin
        checks++;
        if (btn_level[0] !== (e == 6) || btn_rise[0] !== (e == 6) || btn_level[1] !== 1'b0) begin
          errors++;
          $display("FAIL press_edge%0d got lvl=%b rise=%b", e, btn_level, btn_rise);
        end
      end
    end
    for (int e = 1; e <= 10; e++) begin
      tick(2'b00);
      falls += int'(btn_fall[0]);
      if (e == 6) begin
        checks++;
        if (btn_fall[0] !== 1'b1 || btn_level[0] !== 1'b0) begin
          errors++;
          $display("FAIL release_edge6 got fall=%b lvl=%b want 1 0", btn_fall[0], btn_level[0]);
        end
      end
    end
    checks++;
    if (rises != 1 || falls != 1) begin
      errors++;
      $display("FAIL press_pulse_count got rise=%0d fall=%0d want 1 1", rises, falls);
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] pat [8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    int rises = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick(pat[k]);
      checks++;
      if (actv() !== '0) begin
        errors++;
        $display("FAIL bounce_quiet_%0d got=%b want=0", k, actv());
      end
    end
    for (int e = 1; e <= 12; e++) begin
      tick(2'b10);
      rises += int'(btn_rise[1]);
      checks++;
      if (btn_level[1] !== (e >= 6)) begin
        errors++;
        $display("FAIL bounce_level_e%0d got=%b want=%b", e, btn_level[1], e >= 6);
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rise_count got=%0d want=1", rises);
    end
  endtask

  task automatic test_glitch();
    int rises = 0, falls = 0;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      tick((k < 3) ? 2'b01 : 2'b00);
      checks++;
      if (actv() !== '0) begin
        errors++;
        $display("FAIL glitch3_%0d got=%b want=0", k, actv());
      end
    end
    for (int k = 0; k < 16; k++) begin
      tick((k < SC) ? 2'b01 : 2'b00);
      rises += int'(btn_rise[0]);
      falls += int'(btn_fall[0]);
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL glitch4_%0d got=%b want=%b", k, actv(), expv());
      end
    end
    checks++;
    if (rises != 1 || falls != 1) begin
      errors++;
      $display("FAIL glitch4_pulses got rise=%0d fall=%0d want 1 1", rises, falls);
    end
  endtask

  task automatic test_simultaneous();
    int anys = 0;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      tick(2'b11);
      anys += int'(any_change);
      if (e == 6) begin
        checks++;
        if (btn_rise !== 2'b11 || any_change !== 1'b1) begin
          errors++;
          $display("FAIL simul_edge6 got rise=%b any=%b want 11 1", btn_rise, any_change);
        end
      end
    end
    checks++;
    if (anys != 1) begin
      errors++;
      $display("FAIL simul_any_count got=%0d want=1", anys);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int e = 1; e <= 4; e++) tick(2'b01);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (actv() !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b want=0", actv());
    end
    tick(2'b01);
    tick(2'b01);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick(2'b01);
      checks++;
      if (btn_rise[0] !== (e == 6) || btn_level[0] !== (e >= 6)) begin
        errors++;
        $display("FAIL reset_mid_e%0d got rise=%b lvl=%b want %b %b",
                 e, btn_rise[0], btn_level[0], e == 6, e >= 6);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] raw = '0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 3) == 0) raw[c] = ~raw[c];
      tick(raw);
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL random_%0d got=%b want=%b", k, actv(), expv());
      end
      checks++;
      if ((btn_rise & btn_fall) !== '0) begin
        errors++;
        $display("FAIL random_rise_fall_overlap_%0d got rise=%b fall=%b", k, btn_rise, btn_fall);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
